// File: rtl/soundweb_stream_encoder.sv
// rtl/soundweb_stream_encoder.sv - Soundweb packet encoder streaming STX, stuffed body, XOR checksum, ETX
// Captures one message per handshake and emits the framed packet one byte per accepted cycle.
module soundweb_stream_encoder #(
  parameter int MAX_DATA_BYTES = 4,
  parameter bit ESCAPE_EN      = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [7:0]                           command,
  input  logic [47:0]                          address,
  input  logic [15:0]                          sv,
  input  logic [8*MAX_DATA_BYTES-1:0]          data,
  input  logic [$clog2(MAX_DATA_BYTES+1)-1:0]  data_len,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [7:0]                           out_data,
  output logic                                 out_sop,
  output logic                                 out_eop,
  output logic                                 busy,
  output logic [15:0]                          pkt_count
);

  localparam int LW       = $clog2(MAX_DATA_BYTES + 1);
  localparam int BODY_MAX = 9 + MAX_DATA_BYTES;
  localparam int IW       = $clog2(BODY_MAX);

  localparam logic [7:0] STX_BYTE = 8'h02;
  localparam logic [7:0] ETX_BYTE = 8'h03;
  localparam logic [7:0] ESC_BYTE = 8'h1B;

  typedef enum logic [2:0] {
    S_IDLE, S_STX, S_BODY, S_ESC, S_CSUM, S_CSUM_ESC, S_ETX
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   last_q;
  logic [7:0]      csum_q;
  logic [15:0]     pkt_count_q;
  logic [7:0]      body_q  [BODY_MAX];
  logic [7:0]      body_in [BODY_MAX];
  logic [7:0]      csum_in;
  logic [LW-1:0]   len_c;
  logic [7:0]      cur;
  logic            accept;
  logic            at_last;

  function automatic logic needs_esc(input logic [7:0] b);
    return ESCAPE_EN && (b == 8'h02 || b == 8'h03 || b == 8'h06 ||
                         b == 8'h15 || b == 8'h1B);
  endfunction

  // Body layout and checksum are computed from the live inputs so they can be latched on accept.
  always_comb begin
    len_c = (data_len > LW'(MAX_DATA_BYTES)) ? LW'(MAX_DATA_BYTES) : data_len;
    body_in[0] = command;
    for (int i = 0; i < 6; i++) body_in[1+i] = address[8*i +: 8];
    body_in[7] = sv[7:0];
    body_in[8] = sv[15:8];
    for (int i = 0; i < MAX_DATA_BYTES; i++) body_in[9+i] = data[8*i +: 8];
    csum_in = 8'h00;
    for (int i = 0; i < 9; i++) csum_in = csum_in ^ body_in[i];
    for (int i = 0; i < MAX_DATA_BYTES; i++) begin
      if (i < int'(len_c)) csum_in = csum_in ^ data[8*i +: 8];
    end
  end

  assign accept    = in_valid && (state_q == S_IDLE);
  assign cur       = body_q[idx_q];
  assign at_last   = (idx_q == last_q);
  assign out_valid = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign pkt_count = pkt_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pkt_count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == S_ETX && out_ready) pkt_count_q <= pkt_count_q + 16'h0001;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < BODY_MAX; i++) body_q[i] <= body_in[i];
      csum_q <= csum_in;
      last_q <= IW'(8) + IW'(len_c);
    end
  end

  // Outputs depend only on registered state, so they hold naturally while out_ready is low.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    out_data = 8'h00;
    out_sop  = 1'b0;
    out_eop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_STX;
          idx_d   = '0;
        end
      end
      S_STX: begin
        out_data = STX_BYTE;
        out_sop  = 1'b1;
        if (out_ready) state_d = S_BODY;
      end
      S_BODY: begin
        if (needs_esc(cur)) begin
          out_data = ESC_BYTE;
          if (out_ready) state_d = S_ESC;
        end else begin
          out_data = cur;
          if (out_ready) begin
            if (at_last) state_d = S_CSUM;
            else         idx_d   = idx_q + IW'(1);
          end
        end
      end
      S_ESC: begin
        out_data = cur + 8'h80;
        if (out_ready) begin
          if (at_last) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_BODY;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      S_CSUM: begin
        if (needs_esc(csum_q)) begin
          out_data = ESC_BYTE;
          if (out_ready) state_d = S_CSUM_ESC;
        end else begin
          out_data = csum_q;
          if (out_ready) state_d = S_ETX;
        end
      end
      S_CSUM_ESC: begin
        out_data = csum_q + 8'h80;
        if (out_ready) state_d = S_ETX;
      end
      S_ETX: begin
        out_data = ETX_BYTE;
        out_eop  = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_soundweb_stream_encoder.sv
// tb/tb_soundweb_stream_encoder.sv - directed and randomized checks of soundweb_stream_encoder
module tb_soundweb_stream_encoder;

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  command = '0;
  logic [47:0] address = '0;
  logic [15:0] sv = '0;
  logic [31:0] data = '0;
  logic [2:0]  data_len = '0;
  logic        out_valid, out_ready = 1'b1, out_sop, out_eop, busy;
  logic [7:0]  out_data;
  logic [15:0] pkt_count;

  logic        r_in_valid = 1'b0, r_in_ready;
  logic        r_out_valid, r_out_ready = 1'b1, r_out_sop, r_out_eop, r_busy;
  logic [7:0]  r_out_data;
  logic [15:0] r_pkt_count;

  int errors = 0;
  int checks = 0;
  int exp_pkts = 0;

  always #5 clk = ~clk;

  soundweb_stream_encoder #(.MAX_DATA_BYTES(4), .ESCAPE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .command(command), .address(address), .sv(sv), .data(data), .data_len(data_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .pkt_count(pkt_count)
  );

  soundweb_stream_encoder #(.MAX_DATA_BYTES(4), .ESCAPE_EN(1'b0)) dut_raw (
    .clk(clk), .reset(reset), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .command(command), .address(address), .sv(sv), .data(data), .data_len(data_len),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
    .out_sop(r_out_sop), .out_eop(r_out_eop), .busy(r_busy), .pkt_count(r_pkt_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: list the body bytes, fold the checksum, then stuff whatever is in the escape set.
  function automatic bq_t model(input logic [7:0] c, input logic [47:0] a, input logic [15:0] s,
                                input logic [31:0] d, input int len, input bit esc);
    bq_t body, q;
    logic [7:0] cs = 8'h00;
    int n = (len > 4) ? 4 : len;
    body.push_back(c);
    for (int i = 0; i < 6; i++) body.push_back(a[8*i +: 8]);
    body.push_back(s[7:0]);
    body.push_back(s[15:8]);
    for (int i = 0; i < n; i++) body.push_back(d[8*i +: 8]);
    foreach (body[i]) cs = cs ^ body[i];
    body.push_back(cs);
    q.push_back(8'h02);
    foreach (body[i]) begin
      if (esc && body[i] inside {8'h02, 8'h03, 8'h06, 8'h15, 8'h1B}) begin
        q.push_back(8'h1B);
        q.push_back(body[i] + 8'h80);
      end else begin
        q.push_back(body[i]);
      end
    end
    q.push_back(8'h03);
    return q;
  endfunction

  function automatic logic [7:0] pick();
    logic [7:0] set [5] = '{8'h02, 8'h03, 8'h06, 8'h15, 8'h1B};
    if ($urandom_range(0, 2) == 0) return set[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  task automatic run_packet(input logic [7:0] c, input logic [47:0] a, input logic [15:0] s,
                            input logic [31:0] d, input logic [2:0] l, input bit bp,
                            input int abort_at);
    bq_t exp_q, got;
    bit done = 0;
    bit stalled = 0;
    logic [7:0] prev_d = 8'h00;
    exp_q = model(c, a, s, d, int'(l), 1'b1);
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    command = c; address = a; sv = s; data = d; data_len = l; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("stx_latency", {31'd0, out_valid}, 32'd1);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      check("busy", {31'd0, busy}, 32'd1);
      check("out_valid_gapless", {31'd0, out_valid}, 32'd1);
      if (stalled) check("hold_data", {24'd0, out_data}, {24'd0, prev_d});
      if (out_ready) begin
        check("sop", {31'd0, out_sop}, {31'd0, got.size() == 0});
        check("eop", {31'd0, out_eop}, {31'd0, got.size() == exp_q.size() - 1});
        got.push_back(out_data);
        if (out_eop || got.size() > exp_q.size()) done = 1;
        if (abort_at != 0 && got.size() == abort_at) begin
          @(negedge clk);
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          out_ready = 1'b1;
          exp_pkts = 0;
          check("abort_out_valid", {31'd0, out_valid}, 32'd0);
          check("abort_in_ready", {31'd0, in_ready}, 32'd1);
          check("abort_pkt_count", {16'd0, pkt_count}, 32'd0);
          return;
        end
      end
      stalled = !out_ready;
      prev_d = out_data;
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("pkt_done", {31'd0, done}, 32'd1);
    exp_pkts++;
    check("in_ready_after", {31'd0, in_ready}, 32'd1);
    check("out_valid_after", {31'd0, out_valid}, 32'd0);
    check("pkt_count", {16'd0, pkt_count}, exp_pkts);
    check("pkt_len", got.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got.size()) check($sformatf("byte%0d", i), {24'd0, got[i]}, {24'd0, exp_q[i]});
    end
  endtask

  localparam logic [47:0] NOM_A = 48'h00_01_00_03_01_10;

  initial begin
    bq_t rexp, rgot;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_sop_eop", {30'd0, out_sop, out_eop}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
    reset = 1'b0;

    run_packet(8'h88, NOM_A, 16'h0000, 32'h0100_0000, 3'd4, 1'b0, 0);
    run_packet(8'h06, 48'd0, 16'h0000, 32'h0, 3'd4, 1'b0, 0);
    run_packet(8'h88, NOM_A, 16'h0000, 32'h0, 3'd2, 1'b0, 0);
    run_packet(8'h88, NOM_A, 16'h0000, 32'h0100_0000, 3'd7, 1'b0, 0);
    run_packet(8'h88, NOM_A, 16'h0000, 32'h0100_0000, 3'd4, 1'b1, 0);
    run_packet(8'h88, NOM_A, 16'h0000, 32'h0100_0000, 3'd4, 1'b1, 6);
    run_packet(8'h88, NOM_A, 16'h0000, 32'h0100_0000, 3'd4, 1'b0, 0);

    for (int t = 0; t < 12; t++) begin
      logic [47:0] a;
      logic [31:0] d;
      for (int i = 0; i < 6; i++) a[8*i +: 8] = pick();
      for (int i = 0; i < 4; i++) d[8*i +: 8] = pick();
      run_packet(pick(), a, {pick(), pick()}, d, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 0);
    end

    rexp = model(8'h06, 48'd0, 16'h0000, 32'h0, 4, 1'b0);
    @(negedge clk);
    command = 8'h06; address = '0; sv = '0; data = '0; data_len = 3'd4; r_in_valid = 1'b1;
    @(negedge clk);
    r_in_valid = 1'b0;
    for (int cyc = 0; cyc < 60 && r_out_valid; cyc++) begin
      rgot.push_back(r_out_data);
      @(negedge clk);
    end
    check("raw_len", rgot.size(), rexp.size());
    foreach (rexp[i]) begin
      if (i < rgot.size()) check($sformatf("raw_byte%0d", i), {24'd0, rgot[i]}, {24'd0, rexp[i]});
    end
    check("raw_pkt_count", {16'd0, r_pkt_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
